// File: rtl/mul_seq_16.sv
// ---------------------------------------------------------------------------
// mul_seq_16 -- 16 x 16 unsigned sequential shift-add multiplier
//
// One 16-bit ripple adder is shared by all sixteen iterations. The partial
// product lives in {ph, pl}. pl starts out holding the multiplier and is
// shifted out bit by bit while the product bits shift in behind it.
//
// Ports:
//   clk     in   1   single clock, rising-edge active
//   rst     in   1   asynchronous active-high reset
//   start   in   1   request pulse, sampled on the rising edge of clk
//   mcand   in  16   unsigned multiplicand, sampled with start
//   mplier  in  16   unsigned multiplier, sampled with start
//   busy    out  1   high while iterating (state RUN)
//   done    out  1   one-cycle completion strobe (state DONE)
//   prod    out 32   registered unsigned product
//
// Optional feature:
//   MUL_EARLY_EXIT_EN  When defined, a start with a zero operand loads
//                      prod = 0 and goes straight to DONE. busy never rises
//                      for that request.
// ---------------------------------------------------------------------------
module mul_seq_16 (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] mcand,
    input  logic [15:0] mplier,
    output logic        busy,
    output logic        done,
    output logic [31:0] prod
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [15:0] a;
    logic [15:0] ph;
    logic [15:0] pl;
    logic [3:0]  cnt;

    logic [15:0] addend;
    logic [16:0] add_res;
    logic        zero_op;
    logic        load_op;
    logic        step;
    logic        finish;

    // The single shared ripple adder. Locals are used so the carry chain
    // stays inside the function rather than forming a self-referencing
    // vector at module level.
    function automatic logic [16:0] ripple_add16(
        input logic [15:0] x,
        input logic [15:0] y,
        input logic        cin
    );
        logic [15:0] s;
        logic        c;
        c = cin;
        s = '0;
        for (int i = 0; i < 16; i++) begin
            s[i] = x[i] ^ y[i] ^ c;
            c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
        end
        return {c, s};
    endfunction

    // Add the multiplicand into the high half only when the current
    // multiplier bit is set. The carry-out becomes the new top product bit,
    // so nothing is truncated.
    always_comb begin
        addend  = pl[0] ? a : 16'h0000;
        add_res = ripple_add16(ph, addend, 1'b0);
    end

    // Zero-operand detection only matters when the fast path is built in.
    // Otherwise zero operands simply run the full sixteen iterations.
    always_comb begin
`ifdef MUL_EARLY_EXIT_EN
        zero_op = (mcand == 16'h0000) || (mplier == 16'h0000);
`else
        zero_op = 1'b0;
`endif
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and control strobes.
    // A start request is honoured in IDLE and also in DONE, which allows
    // back-to-back operation. A start request in RUN is ignored.
    always_comb begin
        state_next = state;
        load_op    = 1'b0;
        step       = 1'b0;
        finish     = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    load_op    = 1'b1;
                    state_next = zero_op ? DONE : RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                step = 1'b1;
                if (cnt == 4'd15) begin
                    finish     = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    load_op    = 1'b1;
                    state_next = zero_op ? DONE : RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath registers.
    // Each iteration shifts {carry, sum, pl[15:1]} into {ph, pl}.
    // prod is written only on the final iteration (or on a fast-path zero
    // request), so the previous result stays visible while the next
    // operation runs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a    <= 16'h0000;
            ph   <= 16'h0000;
            pl   <= 16'h0000;
            cnt  <= 4'd0;
            prod <= 32'h0000_0000;
        end else begin
            if (load_op) begin
                a   <= mcand;
                ph  <= 16'h0000;
                pl  <= mplier;
                cnt <= 4'd0;
            end else if (step) begin
                {ph, pl} <= {add_res, pl[15:1]};
                cnt      <= cnt + 4'd1;
            end

            if (finish) begin
                prod <= {add_res, pl[15:1]};
            end else if (load_op && zero_op) begin
                prod <= 32'h0000_0000;
            end
        end
    end

endmodule

// File: tb/tb_mul_seq_16.sv
// ---------------------------------------------------------------------------
// tb_mul_seq_16 -- self-checking bench for mul_seq_16
//
// The expected products come from plain 32-bit multiplication. Expected
// timing is expressed as the index of the clock period in which done is
// seen. Period 1 is the one that begins at the sampling edge, so the full
// path shows done in period 17 (16 edges later). The zero-operand fast path
// shows done in period 1.
// ---------------------------------------------------------------------------
module tb_mul_seq_16;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] mcand;
    logic [15:0] mplier;
    logic        busy;
    logic        done;
    logic [31:0] prod;

    int          tests_run    = 0;
    int          tests_failed = 0;
    logic [31:0] last_prod;

    always #5 clk = ~clk;

    mul_seq_16 dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .mcand  (mcand),
        .mplier (mplier),
        .busy   (busy),
        .done   (done),
        .prod   (prod)
    );

    // Compare one observed value against its expected value.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Drive the request inputs just after a falling edge.
    task automatic applyStimulus(input logic s, input logic [15:0] x, input logic [15:0] y);
        @(negedge clk);
        start  = s;
        mcand  = x;
        mplier = y;
    endtask

    // Run one multiplication and check its timing, busy width and result.
    //   pre_applied : start is already high, so wait for the sampling edge
    //   poke_at     : period in which to re-raise start with 1 x 1 (-1 = never)
    //   chain       : raise start with nx/ny in the done period
    task automatic runMultiply(input logic [15:0] x, input logic [15:0] y,
                               input bit pre_applied, input int poke_at,
                               input bit chain, input logic [15:0] nx,
                               input logic [15:0] ny);
        int          period;
        int          busy_periods;
        int          exp_period;
        int          exp_busy;
        logic [31:0] exp_prod;

        exp_prod   = 32'(x) * 32'(y);
        exp_period = 17;
        exp_busy   = 16;
`ifdef MUL_EARLY_EXIT_EN
        if (x == 16'h0000 || y == 16'h0000) begin
            exp_period = 1;
            exp_busy   = 0;
        end
`endif
        if (!pre_applied) applyStimulus(1'b1, x, y);
        @(posedge clk);
        period       = 0;
        busy_periods = 0;
        while (period < 40) begin
            @(negedge clk);
            period++;
            if (period == 1) start = 1'b0;
            if (period == poke_at) begin
                start  = 1'b1;
                mcand  = 16'h0001;
                mplier = 16'h0001;
            end else if (period == poke_at + 1) begin
                start = 1'b0;
            end
            if (busy) busy_periods++;
            if (period == 8) checkOutput("prod_held", prod, last_prod);
            if (done) break;
        end
        checkOutput("done_period", period, exp_period);
        checkOutput("busy_periods", busy_periods, exp_busy);
        checkOutput("prod", prod, exp_prod);
        last_prod = exp_prod;
        if (chain) begin
            start  = 1'b1;
            mcand  = nx;
            mplier = ny;
        end else begin
            @(negedge clk);
            checkOutput("done_pulse", done, 1'b0);
        end
    endtask

    // A global time limit keeps a stuck design from hanging the run.
    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] time limit reached");
    end

    initial begin
        int done_seen;
        logic [15:0] rx;
        logic [15:0] ry;

        rst       = 1'b1;
        start     = 1'b0;
        mcand     = 16'h0000;
        mplier    = 16'h0000;
        last_prod = 32'h0;

        // Reset takes effect before any clock edge.
        #1;
        checkOutput("reset_prod_async", prod, 32'h0);
        checkOutput("reset_busy_async", busy, 1'b0);
        #11;
        checkOutput("reset_done", done, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Basic product, then the all-ones case that drives every carry.
        runMultiply(16'h0003, 16'h0005, 1'b0, -1, 1'b0, 16'h0, 16'h0);
        runMultiply(16'hFFFF, 16'hFFFF, 1'b0, -1, 1'b0, 16'h0, 16'h0);
        checkOutput("max_const", prod, 32'hFFFE_0001);

        // A start raised during RUN must not disturb the operation.
        runMultiply(16'h1234, 16'h0010, 1'b0, 5, 1'b0, 16'h0, 16'h0);
        done_seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        checkOutput("no_extra_done", done_seen, 0);
        checkOutput("ignore_prod", prod, 32'h0001_2340);

        // Back-to-back operation: the next start is raised in the done period.
        runMultiply(16'h00FF, 16'h0101, 1'b0, -1, 1'b1, 16'h8000, 16'h0002);
        runMultiply(16'h8000, 16'h0002, 1'b1, -1, 1'b0, 16'h0, 16'h0);
        checkOutput("b2b_prod", prod, 32'h0001_0000);

        // Reset in the middle of an operation clears everything at once.
        applyStimulus(1'b1, 16'hABCD, 16'h1234);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("midrst_busy", busy, 1'b0);
        checkOutput("midrst_done", done, 1'b0);
        checkOutput("midrst_prod", prod, 32'h0);
        @(negedge clk);
        rst       = 1'b0;
        last_prod = 32'h0;
        done_seen = 0;
        repeat (25) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        checkOutput("midrst_no_done", done_seen, 0);
        runMultiply(16'h0002, 16'h0003, 1'b0, -1, 1'b0, 16'h0, 16'h0);

        // Zero operands use the fast path when it is built in.
        runMultiply(16'h0000, 16'h1234, 1'b0, -1, 1'b0, 16'h0, 16'h0);
        runMultiply(16'h5555, 16'h0000, 1'b0, -1, 1'b0, 16'h0, 16'h0);

        // Random operands, with a zero mixed in now and then.
        for (int i = 0; i < 12; i++) begin
            rx = 16'($urandom);
            ry = 16'($urandom);
            if (i % 5 == 4) ry = 16'h0000;
            runMultiply(rx, ry, 1'b0, -1, 1'b0, 16'h0, 16'h0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mul_seq_16.md
MUL_SEQ_16 -- requirements
Module: mul_seq_16

Interface
REQ-001 Parameters: none; operand width fixed at 16 bits, product at 32 bits.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request pulse; sampled on rising edge of clk.
REQ-005 mcand  input  16  multiplicand (unsigned), sampled with start.
REQ-006 mplier  input  16  multiplier (unsigned), sampled with start.
REQ-007 busy  output  1  high while an operation is iterating.
REQ-008 done  output  1  single-cycle completion strobe.
REQ-009 prod  output  32  unsigned product; registered.

Function
REQ-010 Shift-add multiplier sharing exactly one 16-bit ripple adder (sum, carry-out, carry-in) across all iterations; carry-in tied 0.
REQ-011 Internal regs: a[15:0] (multiplicand), ph[15:0] (partial high), pl[15:0] (multiplier/partial low), cnt[3:0], state.
REQ-012 States: IDLE, RUN, DONE; one-hot or binary encoding, implementer's choice.
REQ-013 IDLE: start=1 -> load a=mcand, ph=0, pl=mplier, cnt=0; go RUN. start=0 -> stay.
REQ-014 RUN, each cycle: adder computes ph + (pl[0] ? a : 0) -> {c,sum}; next {ph,pl} = {c,sum,pl[15:1]}; cnt increments.
REQ-015 RUN with cnt==15: perform final iteration, load prod with resulting {ph,pl}, go DONE.
REQ-016 DONE: lasts exactly one cycle; start=1 -> load as REQ-013, go RUN; else go IDLE.
REQ-017 busy = (state==RUN); done = (state==DONE); both combinational decodes of state.
REQ-018 Latency: done high in the cycle beginning 16 rising edges after the edge sampling start.
REQ-019 start asserted while in RUN is ignored; operands and in-flight result unaffected.
REQ-020 prod changes only on completion edge (REQ-015) or reset; held through IDLE and subsequent RUN.
REQ-021 Back-to-back: start in DONE cycle yields next done exactly 16 cycles later; no idle gap required.
REQ-022 Result exact for all 2^32 operand pairs; carry-out of every iteration retained (no truncation).

Reset
REQ-023 rst=1 forces immediately, independent of clk: state=IDLE, busy=0, done=0, prod=0, a=ph=pl=0, cnt=0.
REQ-024 Reset mid-operation abandons the operation; no done pulse produced for it; prod reads 0.
REQ-025 After rst deasserts, first rising edge with start=1 is accepted normally.

Configuration
REQ-026 Macro MUL_EARLY_EXIT_EN selects zero-operand fast path.
REQ-027 Defined: in IDLE/DONE, start=1 with mcand==0 or mplier==0 -> prod=0 loaded, go DONE directly; done high on the cycle after the sampling edge; busy never asserts.
REQ-028 Not defined: zero operands take the full 16-cycle path per REQ-013..REQ-018; result still 0.
REQ-029 Non-zero operands behave identically with or without the macro.

Verification
REQ-030 Basic: reset, start with mcand=0x0003, mplier=0x0005 -> busy high 16 cycles, done one cycle, prod=0x0000000F.
REQ-031 Max: mcand=0xFFFF, mplier=0xFFFF -> prod=0xFFFE0001 at done; carry path exercised.
REQ-032 Busy-start ignore: start 0x1234 x 0x0010, reassert start with 0x0001 x 0x0001 at RUN cycle 5 -> single done at cycle 16, prod=0x00012340.
REQ-033 Back-to-back: 0x00FF x 0x0101 then start in DONE cycle with 0x8000 x 0x0002 -> prod=0x0000FFFF, then prod=0x00010000 exactly 16 cycles later.
REQ-034 Reset mid-op: start 0xABCD x 0x1234, rst pulse at RUN cycle 8 -> busy=0, done=0, prod=0 immediately; no done follows; new start 0x0002 x 0x0003 -> prod=0x00000006.
REQ-035 Zero operand: start 0x0000 x 0x1234 -> with MUL_EARLY_EXIT_EN done 1 cycle later, busy never high; without, done 16 cycles later; prod=0 both.
